// File: rtl/core_pkg.sv
// Shared widths, write-back packet and arbiter state encoding for the
// register-file write-port arbiter.
package core_pkg;

  localparam int WIDTH_REG  = 7;   // physical register address width
  localparam int WIDTH_BRM  = 3;   // branch-mask width, one bit per in-flight branch
  localparam int WIDTH_TAG  = 5;   // ROB tag width
  localparam int WIDTH_DATA = 32;  // result width

  // One write-back request: destination, value, ROB tag and speculation mask.
  typedef struct packed {
    logic [WIDTH_REG-1:0]  addr;
    logic [WIDTH_DATA-1:0] data;
    logic [WIDTH_TAG-1:0]  tag;
    logic [WIDTH_BRM-1:0]  brmask;
  } wb_pkt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // hold empty
    WAIT  = 2'd1,  // hold full, losing arbitration, below the starvation limit
    BLOCK = 2'd2   // hold full and starved: ALU issue is being suppressed
  } arb_state_t;

  // An entry is on a killed path when any of its branch bits is being killed.
  function automatic logic is_killed(input logic [WIDTH_BRM-1:0] mask,
                                     input logic [WIDTH_BRM-1:0] kill);
    return |(mask & kill);
  endfunction

endpackage

// File: rtl/wb_hold_reg.sv
// One-entry hold for a MulDiv result that lost the write port. Squashes
// itself on a branch kill and drops resolved-correct branch bits from its mask.
module wb_hold_reg
  import core_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_capture,  // load i_pkt (only honoured while empty)
  input  wb_pkt_t              i_pkt,
  input  logic                 i_drain,    // held entry is being written this cycle
  input  logic [WIDTH_BRM-1:0] i_brkill,
  input  logic [WIDTH_BRM-1:0] i_brok,
  output logic                 o_full,
  output wb_pkt_t              o_pkt
);

  logic    killed;
  wb_pkt_t cap_pkt;

  assign killed = o_full & is_killed(o_pkt.brmask, i_brkill);

  // Incoming entry already has this cycle's resolved branches removed from its mask.
  always_comb begin
    cap_pkt        = i_pkt;
    cap_pkt.brmask = i_pkt.brmask & ~i_brok;
  end

  // Hold register: empties on drain or kill, otherwise tracks branch resolution.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_full <= 1'b0;
      o_pkt  <= '0;
    end else if (o_full) begin
      if (killed || i_drain) begin
        o_full <= 1'b0;
      end else begin
        o_pkt.brmask <= o_pkt.brmask & ~i_brok;
      end
    end else if (i_capture) begin
      o_full <= 1'b1;
      o_pkt  <= cap_pkt;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares one register-file write port between the non-stallable ALU pipe and
// the MulDiv unit. ALU always wins; a losing MulDiv result waits in a
// one-entry hold, and a starvation counter asks the ALU issue queue to back off.
//
// Handshake: a MulDiv result transfers in any cycle where i_md_valid and
// o_md_ready are both high at the rising edge. o_md_ready depends only on
// registered state (hold empty), never on same-cycle inputs. The ALU side has
// no backpressure: i_alu_valid is a fire-and-forget strobe.
module wb_port_arbiter
  import core_pkg::*;
#(
  parameter int MAX_WAIT = 4  // losses tolerated before o_alu_block (>= 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_alu_valid,
  input  logic [WIDTH_REG-1:0]  i_alu_addr,
  input  logic [WIDTH_DATA-1:0] i_alu_data,
  input  logic [WIDTH_TAG-1:0]  i_alu_tag,
  input  logic [WIDTH_BRM-1:0]  i_alu_brmask,
  input  logic                  i_md_valid,
  output logic                  o_md_ready,
  input  logic [WIDTH_REG-1:0]  i_md_addr,
  input  logic [WIDTH_DATA-1:0] i_md_data,
  input  logic [WIDTH_TAG-1:0]  i_md_tag,
  input  logic [WIDTH_BRM-1:0]  i_md_brmask,
  input  logic [WIDTH_BRM-1:0]  i_brkill,
  input  logic [WIDTH_BRM-1:0]  i_brok,
  output logic                  o_we,
  output logic [WIDTH_REG-1:0]  o_waddr,
  output logic [WIDTH_DATA-1:0] o_wdata,
  output logic [WIDTH_TAG-1:0]  o_tag,
  output logic                  o_alu_block,
  output arb_state_t            o_dbg_state
);

  localparam int             CW      = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_WAIT);

  wb_pkt_t               md_pkt;
  wb_pkt_t               hold_pkt;
  logic                  hold_full;
  logic                  hold_kill;
  logic                  alu_kill;
  logic                  md_kill;
  logic                  md_xfer;
  logic                  alu_win;
  logic                  hold_win;
  logic                  md_win;
  logic                  capture;
  logic [WIDTH_REG-1:0]  win_addr;
  logic [WIDTH_DATA-1:0] win_data;
  logic [WIDTH_TAG-1:0]  win_tag;
  arb_state_t            state;
  arb_state_t            state_nxt;
  logic [CW-1:0]         wait_cnt;
  logic [CW-1:0]         cnt_nxt;
  logic [CW-1:0]         cnt_inc;

  assign md_pkt = '{addr: i_md_addr, data: i_md_data, tag: i_md_tag, brmask: i_md_brmask};

  assign o_md_ready = ~hold_full;
  assign md_xfer    = i_md_valid & ~hold_full;

  assign alu_kill  = is_killed(i_alu_brmask, i_brkill);
  assign md_kill   = is_killed(i_md_brmask, i_brkill);
  assign hold_kill = hold_full & is_killed(hold_pkt.brmask, i_brkill);

  // Fixed priority: ALU, then held MulDiv, then a MulDiv bypass straight to the port.
  assign alu_win  = i_alu_valid & ~alu_kill;
  assign hold_win = ~alu_win & hold_full & ~hold_kill;
  assign md_win   = ~alu_win & ~hold_full & md_xfer & ~md_kill;
  assign capture  = md_xfer & ~md_win & ~md_kill;

  wb_hold_reg u_hold (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_capture (capture),
    .i_pkt     (md_pkt),
    .i_drain   (hold_win),
    .i_brkill  (i_brkill),
    .i_brok    (i_brok),
    .o_full    (hold_full),
    .o_pkt     (hold_pkt)
  );

  // Select the fields of whichever source wins the port this cycle.
  always_comb begin
    win_addr = i_alu_addr;
    win_data = i_alu_data;
    win_tag  = i_alu_tag;
    if (hold_win) begin
      win_addr = hold_pkt.addr;
      win_data = hold_pkt.data;
      win_tag  = hold_pkt.tag;
    end else if (md_win) begin
      win_addr = i_md_addr;
      win_data = i_md_data;
      win_tag  = i_md_tag;
    end
  end

  // Write-port output flops; address/data/tag hold their last value on idle cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_we    <= 1'b0;
      o_waddr <= '0;
      o_wdata <= '0;
      o_tag   <= '0;
    end else begin
      o_we <= alu_win | hold_win | md_win;
      if (alu_win || hold_win || md_win) begin
        o_waddr <= win_addr;
        o_wdata <= win_data;
        o_tag   <= win_tag;
      end
    end
  end

  // Saturating increment of the loss counter.
  assign cnt_inc = (wait_cnt == MAX_CNT) ? wait_cnt : wait_cnt + CW'(1);

  // Starvation FSM next state: the capture cycle counts as the first loss.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = wait_cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (capture) begin
          cnt_nxt   = CW'(1);
          state_nxt = (MAX_CNT == CW'(1)) ? BLOCK : WAIT;
        end
      end
      WAIT: begin
        if (hold_win || hold_kill) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == MAX_CNT) state_nxt = BLOCK;
        end
      end
      BLOCK: begin
        if (hold_win || hold_kill) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // FSM state, wait counter and the registered ALU-block request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      o_alu_block <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= cnt_nxt;
      o_alu_block <= (state_nxt == BLOCK);
    end
  end

  assign o_dbg_state = state;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios followed by random traffic,
// checked every cycle against a transaction-level model of the write port.
module tb_wb_port_arbiter;
  import core_pkg::*;

  localparam int MAX_WAIT = 4;
  localparam int PW       = WIDTH_REG + WIDTH_DATA + WIDTH_TAG;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                  alu_valid;
  logic [WIDTH_REG-1:0]  alu_addr;
  logic [WIDTH_DATA-1:0] alu_data;
  logic [WIDTH_TAG-1:0]  alu_tag;
  logic [WIDTH_BRM-1:0]  alu_brmask;
  logic                  md_valid;
  logic                  md_ready;
  logic [WIDTH_REG-1:0]  md_addr;
  logic [WIDTH_DATA-1:0] md_data;
  logic [WIDTH_TAG-1:0]  md_tag;
  logic [WIDTH_BRM-1:0]  md_brmask;
  logic [WIDTH_BRM-1:0]  brkill;
  logic [WIDTH_BRM-1:0]  brok;
  logic                  we;
  logic [WIDTH_REG-1:0]  waddr;
  logic [WIDTH_DATA-1:0] wdata;
  logic [WIDTH_TAG-1:0]  wtag;
  logic                  alu_block;
  arb_state_t            dbg_state;

  wb_port_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_alu_valid  (alu_valid),
    .i_alu_addr   (alu_addr),
    .i_alu_data   (alu_data),
    .i_alu_tag    (alu_tag),
    .i_alu_brmask (alu_brmask),
    .i_md_valid   (md_valid),
    .o_md_ready   (md_ready),
    .i_md_addr    (md_addr),
    .i_md_data    (md_data),
    .i_md_tag     (md_tag),
    .i_md_brmask  (md_brmask),
    .i_brkill     (brkill),
    .i_brok       (brok),
    .o_we         (we),
    .o_waddr      (waddr),
    .o_wdata      (wdata),
    .o_tag        (wtag),
    .o_alu_block  (alu_block),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks what is waiting in the hold and how many cycles it has lost.
  logic                  m_full;
  logic [WIDTH_REG-1:0]  m_addr;
  logic [WIDTH_DATA-1:0] m_data;
  logic [WIDTH_TAG-1:0]  m_tag;
  logic [WIDTH_BRM-1:0]  m_mask;
  int                    m_losses;
  logic                  m_we;
  logic [PW-1:0]         m_last;
  logic [PW-1:0]         exp_q[$];

  task automatic model_reset();
    m_full   = 1'b0;
    m_addr   = '0;
    m_data   = '0;
    m_tag    = '0;
    m_mask   = '0;
    m_losses = 0;
    m_we     = 1'b0;
    m_last   = '0;
    exp_q.delete();
  endtask

  // Apply one cycle of the arbitration rules to the current inputs.
  task automatic model_step();
    bit ka, kh, km, md_go, used_md, drained;
    ka      = (alu_brmask & brkill) != 0;
    kh      = m_full && ((m_mask & brkill) != 0);
    km      = (md_brmask & brkill) != 0;
    md_go   = md_valid && !m_full;
    used_md = 1'b0;
    drained = 1'b0;
    m_we    = 1'b0;
    if (alu_valid && !ka) begin
      m_we = 1'b1;
      exp_q.push_back({alu_addr, alu_data, alu_tag});
    end else if (m_full && !kh) begin
      m_we = 1'b1;
      exp_q.push_back({m_addr, m_data, m_tag});
      drained = 1'b1;
    end else if (md_go && !km) begin
      m_we = 1'b1;
      exp_q.push_back({md_addr, md_data, md_tag});
      used_md = 1'b1;
    end
    if (drained || kh) begin
      m_full   = 1'b0;
      m_losses = 0;
    end else if (m_full) begin
      m_mask = m_mask & ~brok;
      if (m_losses < MAX_WAIT) m_losses++;
    end else if (md_go && !km && !used_md) begin
      m_full   = 1'b1;
      m_addr   = md_addr;
      m_data   = md_data;
      m_tag    = md_tag;
      m_mask   = md_brmask & ~brok;
      m_losses = 1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    alu_valid  = 1'b0;
    alu_addr   = '0;
    alu_data   = '0;
    alu_tag    = '0;
    alu_brmask = '0;
    md_valid   = 1'b0;
    md_addr    = '0;
    md_data    = '0;
    md_tag     = '0;
    md_brmask  = '0;
    brkill     = '0;
    brok       = '0;
  endtask

  task automatic drive_alu(input logic [WIDTH_REG-1:0] a, input logic [WIDTH_DATA-1:0] d,
                           input logic [WIDTH_TAG-1:0] t, input logic [WIDTH_BRM-1:0] m);
    alu_valid  = 1'b1;
    alu_addr   = a;
    alu_data   = d;
    alu_tag    = t;
    alu_brmask = m;
  endtask

  task automatic drive_md(input logic [WIDTH_REG-1:0] a, input logic [WIDTH_DATA-1:0] d,
                          input logic [WIDTH_TAG-1:0] t, input logic [WIDTH_BRM-1:0] m);
    md_valid  = 1'b1;
    md_addr   = a;
    md_data   = d;
    md_tag    = t;
    md_brmask = m;
  endtask

  // One clock: predict, clock, then compare every output 1 time unit after the edge.
  task automatic cycle();
    arb_state_t exp_state;
    logic       exp_block;
    model_step();
    @(posedge clk);
    #1;
    exp_block = m_full && (m_losses >= MAX_WAIT);
    exp_state = !m_full ? IDLE : (exp_block ? BLOCK : WAIT);
    check("we", we, m_we);
    if (m_we) begin
      if (exp_q.size() == 0) check("exp_q_empty", 1, 0);
      else m_last = exp_q.pop_front();
    end
    check("wpkt", {waddr, wdata, wtag}, m_last);
    check("md_ready", md_ready, !m_full);
    check("alu_block", alu_block, exp_block);
    check("state", dbg_state, exp_state);
  endtask

  function automatic logic [WIDTH_BRM-1:0] rand_onehot(input int pct);
    logic [WIDTH_BRM-1:0] v;
    v = '0;
    if ($urandom_range(0, 99) < pct) v[$urandom_range(0, WIDTH_BRM-1)] = 1'b1;
    return v;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    model_reset();

    // Reset with every input high: outputs cleared, hold empty.
    rst_n      = 1'b0;
    alu_valid  = 1'b1;
    alu_addr   = '1;
    alu_data   = '1;
    alu_tag    = '1;
    alu_brmask = '1;
    md_valid   = 1'b1;
    md_addr    = '1;
    md_data    = '1;
    md_tag     = '1;
    md_brmask  = '1;
    brkill     = '1;
    brok       = '1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", we, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_tag", wtag, 0);
    check("rst_alu_block", alu_block, 0);
    check("rst_md_ready", md_ready, 1);
    check("rst_state", dbg_state, IDLE);
    set_idle();
    rst_n = 1'b1;
    cycle();

    // MulDiv alone bypasses straight to the port.
    drive_md(7'd9, 32'h1234, 5'd3, 3'b000);
    cycle();
    set_idle();
    cycle();

    // ALU and MulDiv together: ALU first, held MulDiv next.
    drive_alu(7'd5, 32'hA5A5_0005, 5'd1, 3'b000);
    drive_md(7'd9, 32'h0000_9999, 5'd2, 3'b000);
    cycle();
    set_idle();
    cycle();
    cycle();

    // Starvation: ALU every cycle until the block request rises, then drops.
    drive_alu(7'd10, 32'h1, 5'd4, 3'b000);
    drive_md(7'd20, 32'hBEEF, 5'd6, 3'b000);
    cycle();
    md_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_alu(7'(11 + i), 32'(i + 2), 5'(i), 3'b000);
      cycle();
    end
    set_idle();
    cycle();
    cycle();

    // Kill of a held entry; ALU on another branch still writes.
    drive_alu(7'd1, 32'h11, 5'd7, 3'b000);
    drive_md(7'd2, 32'h22, 5'd8, 3'b010);
    cycle();
    set_idle();
    drive_alu(7'd3, 32'h33, 5'd9, 3'b001);
    brkill = 3'b010;
    cycle();
    set_idle();
    cycle();

    // Resolved branch clears the held bit so a later kill misses it.
    drive_alu(7'd4, 32'h44, 5'd10, 3'b000);
    drive_md(7'd6, 32'h66, 5'd11, 3'b100);
    cycle();
    set_idle();
    drive_alu(7'd8, 32'h88, 5'd12, 3'b000);
    brok = 3'b100;
    cycle();
    set_idle();
    drive_alu(7'd12, 32'hCC, 5'd13, 3'b000);
    brkill = 3'b100;
    cycle();
    set_idle();
    cycle();
    cycle();

    // Asynchronous reset while the hold is full drops the entry.
    drive_alu(7'd14, 32'hEE, 5'd14, 3'b000);
    drive_md(7'd15, 32'hFF, 5'd15, 3'b000);
    cycle();
    set_idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_we", we, 0);
    check("arst_md_ready", md_ready, 1);
    check("arst_state", dbg_state, IDLE);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
    cycle();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      alu_valid  = ($urandom_range(0, 99) < 60);
      alu_addr   = WIDTH_REG'($urandom);
      alu_data   = $urandom;
      alu_tag    = WIDTH_TAG'($urandom);
      alu_brmask = ($urandom_range(0, 1) != 0) ? WIDTH_BRM'($urandom) : '0;
      md_valid   = ($urandom_range(0, 99) < 50);
      md_addr    = WIDTH_REG'($urandom);
      md_data    = $urandom;
      md_tag     = WIDTH_TAG'($urandom);
      md_brmask  = ($urandom_range(0, 1) != 0) ? WIDTH_BRM'($urandom) : '0;
      brkill     = rand_onehot(15);
      brok       = rand_onehot(15);
      cycle();
    end
    set_idle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
